// File: rtl/crc9_pipelined_checker.sv
// crc9_pipelined_checker: receive-side CRC-9 checker, divides a {data, crc} codeword by g
// UNROLL bits per clock (MSB first) and reports syndrome, pass/fail, payload and error count.
module crc9_pipelined_checker #(
   parameter int DATA_W = 10,
   parameter int CRC_W = 9,
   parameter logic [CRC_W-1:0] POLY = 9'h103,
   parameter int UNROLL = 4,
   parameter int CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [DATA_W+CRC_W-1:0] cw_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_W-1:0]       data_out,
   output logic [CRC_W-1:0]        syndrome,
   output logic                    crc_ok,
   output logic [CNT_W-1:0]        err_count
);
   localparam int CW_W = DATA_W + CRC_W;
   localparam int NCYC = (CW_W + UNROLL - 1) / UNROLL;
   localparam int SR_W = NCYC * UNROLL;
   localparam int CNT_BITS = $clog2(NCYC + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              state_q, state_d;
   logic [SR_W-1:0]     sr_q, sr_d;
   logic [CRC_W-1:0]    r_q, r_d, r_step;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [CNT_W-1:0]    err_q, err_d;

   // Long division: shift the next codeword bit in, subtract g when the outgoing MSB is set
   always_comb begin
      r_step = r_q;
      for (int k = 0; k < UNROLL; k++)
         r_step = {r_step[CRC_W-2:0], sr_q[SR_W-1-k]} ^ (r_step[CRC_W-1] ? POLY : '0);
   end

   always_comb begin
      state_d = state_q;
      sr_d = sr_q;
      r_d = r_q;
      cnt_d = cnt_q;
      data_d = data_q;
      err_d = err_q;
      case (state_q)
         IDLE:
            if (in_valid) begin
               state_d = SHIFT;
               sr_d = SR_W'(cw_in);
               r_d = '0;
               cnt_d = CNT_BITS'(NCYC - 1);
               data_d = cw_in[CW_W-1:CRC_W];
            end
         SHIFT: begin
            r_d = r_step;
            sr_d = sr_q << UNROLL;
            if (cnt_q == '0) state_d = DONE;
            else cnt_d = cnt_q - CNT_BITS'(1);
         end
         DONE:
            if (out_ready) begin
               state_d = IDLE;
               if (r_q != '0 && err_q != '1) err_d = err_q + CNT_W'(1);
            end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sr_q <= '0;
         r_q <= '0;
         cnt_q <= '0;
         data_q <= '0;
         err_q <= '0;
      end else begin
         state_q <= state_d;
         sr_q <= sr_d;
         r_q <= r_d;
         cnt_q <= cnt_d;
         data_q <= data_d;
         err_q <= err_d;
      end
   end

   assign in_ready = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign data_out = data_q;
   assign syndrome = r_q;
   assign crc_ok = out_valid && r_q == '0;
   assign err_count = err_q;
endmodule

// File: tb/tb_crc9_pipelined_checker.sv
// tb_crc9_pipelined_checker: directed and random checks of the CRC-9 checker,
// default build plus an UNROLL=1 build with a 2-bit error counter.
module tb_crc9_pipelined_checker;
   logic clk = 0, reset = 1;
   logic [18:0] cw_in = '0;
   logic in_valid1 = 0, in_valid2 = 0, out_ready = 0;
   logic in_ready1, out_valid1, crc_ok1, in_ready2, out_valid2, crc_ok2;
   logic [9:0] data_out1, data_out2;
   logic [8:0] syndrome1, syndrome2;
   logic [15:0] err_count1;
   logic [1:0] err_count2;
   int n_chk = 0, n_fail = 0;

   localparam logic [18:0] CW_T1 = 19'b1100000011_000000000;

   always #5 clk = ~clk;

   crc9_pipelined_checker dut1 (
      .clk(clk), .reset(reset), .cw_in(cw_in), .in_valid(in_valid1), .in_ready(in_ready1),
      .out_valid(out_valid1), .out_ready(out_ready), .data_out(data_out1), .syndrome(syndrome1),
      .crc_ok(crc_ok1), .err_count(err_count1)
   );

   crc9_pipelined_checker #(.UNROLL(1), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .cw_in(cw_in), .in_valid(in_valid2), .in_ready(in_ready2),
      .out_valid(out_valid2), .out_ready(out_ready), .data_out(data_out2), .syndrome(syndrome2),
      .crc_ok(crc_ok2), .err_count(err_count2)
   );

   // Polynomial long division by the full 10-bit g = 0x303
   function automatic logic [8:0] ref_syn(input logic [18:0] cw);
      logic [9:0] r;
      r = '0;
      for (int i = 18; i >= 0; i--) begin
         r = {r[8:0], cw[i]};
         if (r[9]) r = r ^ 10'h303;
      end
      return r[8:0];
   endfunction

   task automatic do_reset;
      in_valid1 = 0;
      in_valid2 = 0;
      reset = 1;
      repeat (2) @(negedge clk);
      reset = 0;
      @(negedge clk);
   endtask

   // Sends one codeword to the chosen DUT and returns its result; handoff completes before return
   task automatic run_frame(input bit sel, input logic [18:0] cw, output int lat, output logic [8:0] syn,
                            output logic ok, output logic [9:0] dat, output bit to);
      to = 0;
      lat = 0;
      out_ready = 1;
      cw_in = cw;
      for (int i = 0; i < 40 && !(sel ? in_ready2 : in_ready1); i++) @(negedge clk);
      if (!(sel ? in_ready2 : in_ready1)) to = 1;
      if (sel) in_valid2 = 1;
      else in_valid1 = 1;
      @(negedge clk);
      in_valid1 = 0;
      in_valid2 = 0;
      while (!(sel ? out_valid2 : out_valid1) && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 60) to = 1;
      syn = sel ? syndrome2 : syndrome1;
      ok = sel ? crc_ok2 : crc_ok1;
      dat = sel ? data_out2 : data_out1;
      @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1;
      repeat (3) @(negedge clk);
      reset = 0;
      n_chk += 6;
      if (in_ready1 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready1); end
      if (out_valid1 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid1); end
      if (syndrome1 !== 9'h0) begin n_fail++; $display("FAIL reset_syndrome got %h want 000", syndrome1); end
      if (crc_ok1 !== 1'b0) begin n_fail++; $display("FAIL reset_crc_ok got %b want 0", crc_ok1); end
      if (data_out1 !== 10'h0) begin n_fail++; $display("FAIL reset_data_out got %h want 000", data_out1); end
      if (err_count1 !== 16'h0) begin n_fail++; $display("FAIL reset_err_count got %h want 0", err_count1); end
   endtask

   task automatic test_clean_frames;
      int lat;
      logic [8:0] syn;
      logic ok;
      logic [9:0] dat;
      bit to;
      do_reset();
      run_frame(0, CW_T1, lat, syn, ok, dat, to);
      n_chk += 5;
      if (to || lat != 5) begin n_fail++; $display("FAIL t1_latency got %0d want 5", lat); end
      if (syn !== 9'h000) begin n_fail++; $display("FAIL t1_syndrome got %h want 000", syn); end
      if (ok !== 1'b1) begin n_fail++; $display("FAIL t1_crc_ok got %b want 1", ok); end
      if (dat !== 10'h303) begin n_fail++; $display("FAIL t1_data got %h want 303", dat); end
      if (err_count1 !== 16'd0) begin n_fail++; $display("FAIL t1_err got %0d want 0", err_count1); end
      run_frame(0, {10'h001, 9'h103}, lat, syn, ok, dat, to);
      n_chk += 4;
      if (to || syn !== 9'h000) begin n_fail++; $display("FAIL t2_syndrome got %h want 000", syn); end
      if (ok !== 1'b1) begin n_fail++; $display("FAIL t2_crc_ok got %b want 1", ok); end
      if (dat !== 10'h001) begin n_fail++; $display("FAIL t2_data got %h want 001", dat); end
      if (err_count1 !== 16'd0) begin n_fail++; $display("FAIL t2_err got %0d want 0", err_count1); end
   endtask

   task automatic test_bit_errors;
      logic [18:0] cws [3];
      logic [8:0] exp [3];
      int lat;
      logic [8:0] syn;
      logic ok;
      logic [9:0] dat;
      bit to;
      cws = '{CW_T1 ^ 19'h00001, CW_T1 ^ 19'h00200, CW_T1 ^ 19'h00400};
      exp = '{9'h001, 9'h103, 9'h105};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         run_frame(0, cws[i], lat, syn, ok, dat, to);
         n_chk += 3;
         if (to || syn !== exp[i]) begin n_fail++; $display("FAIL t3_syndrome[%0d] got %h want %h", i, syn, exp[i]); end
         if (ok !== 1'b0) begin n_fail++; $display("FAIL t3_crc_ok[%0d] got %b want 0", i, ok); end
         if (err_count1 !== 16'(i + 1)) begin n_fail++; $display("FAIL t3_err[%0d] got %0d want %0d", i, err_count1, i + 1); end
      end
   endtask

   task automatic test_hold;
      int lat;
      do_reset();
      out_ready = 0;
      cw_in = CW_T1 ^ 19'h00001;
      in_valid1 = 1;
      @(negedge clk);
      cw_in = CW_T1 ^ 19'h00200;
      lat = 0;
      while (!out_valid1 && lat < 60) begin @(negedge clk); lat++; end
      n_chk++;
      if (lat != 5) begin n_fail++; $display("FAIL t4_latency got %0d want 5", lat); end
      for (int i = 0; i < 7; i++) begin
         n_chk++;
         if (out_valid1 !== 1 || in_ready1 !== 0 || syndrome1 !== 9'h001 || crc_ok1 !== 0 || data_out1 !== 10'h303)
         begin
            n_fail++;
            $display("FAIL t4_hold[%0d] got v=%b r=%b s=%h ok=%b d=%h want v=1 r=0 s=001 ok=0 d=303",
                     i, out_valid1, in_ready1, syndrome1, crc_ok1, data_out1);
         end
         @(negedge clk);
      end
      in_valid1 = 0;
      out_ready = 1;
      @(negedge clk);
      n_chk += 2;
      if (out_valid1 !== 0 || in_ready1 !== 1) begin n_fail++; $display("FAIL t4_release got v=%b r=%b want v=0 r=1", out_valid1, in_ready1); end
      if (err_count1 !== 16'd1) begin n_fail++; $display("FAIL t4_err got %0d want 1", err_count1); end
      lat = 0;
      repeat (10) begin @(negedge clk); if (out_valid1) lat++; end
      n_chk++;
      if (lat != 0) begin n_fail++; $display("FAIL t4_ignored_frame got %0d valid cycles want 0", lat); end
   endtask

   task automatic test_reset_mid;
      int seen;
      cw_in = CW_T1 ^ 19'h00001;
      in_valid1 = 1;
      @(negedge clk);
      in_valid1 = 0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (in_ready1 !== 0 || out_valid1 !== 0) begin n_fail++; $display("FAIL t5_busy got r=%b v=%b want r=0 v=0", in_ready1, out_valid1); end
      reset = 1;
      @(negedge clk);
      reset = 0;
      n_chk += 3;
      if (in_ready1 !== 1) begin n_fail++; $display("FAIL t5_in_ready got %b want 1", in_ready1); end
      if (err_count1 !== 16'd0) begin n_fail++; $display("FAIL t5_err got %0d want 0", err_count1); end
      if (syndrome1 !== 9'h0) begin n_fail++; $display("FAIL t5_syndrome got %h want 000", syndrome1); end
      seen = 0;
      repeat (10) begin if (out_valid1) seen++; @(negedge clk); end
      n_chk++;
      if (seen != 0) begin n_fail++; $display("FAIL t5_no_result got %0d valid cycles want 0", seen); end
   endtask

   task automatic test_back_to_back;
      logic [18:0] q [$];
      logic [18:0] cw;
      logic [9:0] d;
      logic [8:0] e;
      int exp_err = 0, got = 0, sent = 0;
      int n = 3000;
      do_reset();
      out_ready = 1;
      in_valid1 = 1;
      for (int cyc = 0; cyc < n * 7 + 200 && got < n; cyc++) begin
         if (out_valid1) begin
            n_chk++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL b2b_unexpected_result got syndrome %h want no result", syndrome1);
            end else begin
               e = ref_syn(q[0]);
               if (syndrome1 !== e || crc_ok1 !== (e == 0) || data_out1 !== q[0][18:9]) begin
                  n_fail++;
                  $display("FAIL b2b_frame[%0d] got s=%h ok=%b d=%h want s=%h ok=%b d=%h",
                           got, syndrome1, crc_ok1, data_out1, e, e == 0, q[0][18:9]);
               end
               if (e != 0) exp_err++;
               void'(q.pop_front());
            end
            got++;
         end
         if (in_ready1 && sent < n) begin
            d = 10'($urandom);
            cw = {d, ref_syn({d, 9'b0})};
            repeat ($urandom_range(0, 3)) cw[$urandom_range(0, 18)] ^= 1'b1;
            q.push_back(cw);
            cw_in = cw;
            sent++;
         end else begin
            cw_in = 19'($urandom);
            if (sent >= n) in_valid1 = 0;
         end
         @(negedge clk);
      end
      in_valid1 = 0;
      n_chk += 2;
      if (got != n) begin n_fail++; $display("FAIL b2b_count got %0d frames want %0d", got, n); end
      if (err_count1 !== 16'(exp_err)) begin n_fail++; $display("FAIL b2b_err got %0d want %0d", err_count1, exp_err); end
   endtask

   task automatic test_unroll1_saturation;
      logic [18:0] cws [5];
      logic [8:0] exp [5];
      logic [1:0] exp_err [5];
      logic [18:0] cw;
      int lat;
      logic [8:0] syn;
      logic ok;
      logic [9:0] dat;
      bit to;
      cws = '{CW_T1, CW_T1 ^ 19'h00200, CW_T1 ^ 19'h00400, CW_T1 ^ 19'h00001, CW_T1 ^ 19'h00001};
      exp = '{9'h000, 9'h103, 9'h105, 9'h001, 9'h001};
      exp_err = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         run_frame(1, cws[i], lat, syn, ok, dat, to);
         n_chk += 4;
         if (to || lat != 19) begin n_fail++; $display("FAIL u1_latency[%0d] got %0d want 19", i, lat); end
         if (syn !== exp[i]) begin n_fail++; $display("FAIL u1_syndrome[%0d] got %h want %h", i, syn, exp[i]); end
         if (dat !== cws[i][18:9]) begin n_fail++; $display("FAIL u1_data[%0d] got %h want %h", i, dat, cws[i][18:9]); end
         if (err_count2 !== exp_err[i]) begin n_fail++; $display("FAIL u1_err[%0d] got %0d want %0d", i, err_count2, exp_err[i]); end
      end
      for (int i = 0; i < 20; i++) begin
         cw = 19'($urandom);
         run_frame(1, cw, lat, syn, ok, dat, to);
         n_chk++;
         if (to || syn !== ref_syn(cw) || ok !== (ref_syn(cw) == 0)) begin
            n_fail++;
            $display("FAIL u1_random[%0d] got s=%h ok=%b want s=%h", i, syn, ok, ref_syn(cw));
         end
      end
      n_chk++;
      if (err_count2 !== 2'd3) begin n_fail++; $display("FAIL u1_saturated got %0d want 3", err_count2); end
   endtask

   initial begin
      test_reset();
      test_clean_frames();
      test_bit_errors();
      test_hold();
      test_reset_mid();
      test_back_to_back();
      test_unroll1_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
